// File: rtl/part_cmd_parser_if.sv
// Byte-in / command-and-bit-out bundle for the UART command parser.
// The parser sits on the slave modport; whoever feeds bytes and drains bits uses master.
interface part_cmd_parser_if #(
    parameter int LEN_BYTES = 2
);
    logic                   rx_valid;
    logic [7:0]             rx_data;
    logic                   cmd_valid;
    logic [2:0]             cmd_code;
    logic [8*LEN_BYTES-1:0] cmd_len;
    logic                   bit_valid;
    logic                   bit_data;
    logic                   bit_last;
    logic                   bit_ready;
    logic                   busy;
    logic                   err;
    logic [2:0]             err_code;
    logic [1:0]             dbg_state;

    modport master (
        output rx_valid, rx_data, bit_ready,
        input  cmd_valid, cmd_code, cmd_len, bit_valid, bit_data, bit_last,
        input  busy, err, err_code, dbg_state
    );

    modport slave (
        input  rx_valid, rx_data, bit_ready,
        output cmd_valid, cmd_code, cmd_len, bit_valid, bit_data, bit_last,
        output busy, err, err_code, dbg_state
    );
endinterface

// File: rtl/part_cmd_parser.sv
// Parses single-letter UART commands with an optional big-endian length and an
// ASCII '0'/'1' payload that is handed out one bit at a time.
module part_cmd_parser #(
    parameter int LEN_BYTES = 2,
    parameter int TIMEOUT   = 100000
) (
    input  logic               clk,
    input  logic               rst,
    part_cmd_parser_if.slave   bus
);
    localparam int W  = 8 * LEN_BYTES;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_cmd_valid;
    logic [2:0]      r_cmd_code;
    logic [W-1:0]    r_cmd_len;
    logic            r_bit_valid;
    logic            r_bit_data;
    logic            r_bit_last;
    logic            r_err;
    logic [2:0]      r_err_code;
    logic [W-1:0]    r_acc;
    logic [2:0]      r_byte_cnt;
    logic [W-1:0]    r_remain;
    logic [TW-1:0]   r_tmo;

    logic [W+7:0]    w_shift;
    logic [W-1:0]    w_acc_next;
    logic            w_accept;
    logic            w_stall;
    logic            w_tmo_hit;
    logic            w_last_len_byte;
    logic            w_is_digit;
    logic [2:0]      w_code;
    logic [1:0]      w_kind;

    // Bit handshake: a bit transfers on any rising edge where bit_valid and
    // bit_ready are both high; bit_valid/bit_data/bit_last hold until then.
    assign w_accept        = r_bit_valid & bus.bit_ready;
    assign w_stall         = r_bit_valid & ~bus.bit_ready;
    assign w_shift         = {r_acc, bus.rx_data};
    assign w_acc_next      = w_shift[W-1:0];
    assign w_last_len_byte = (r_byte_cnt == 3'(LEN_BYTES - 1));
    assign w_is_digit      = (bus.rx_data == "0") || (bus.rx_data == "1");
    // The wait counter is frozen while a bit sits unaccepted.
    assign w_tmo_hit       = (TIMEOUT != 0) && (r_tmo == TMO_LAST) && !bus.rx_valid && !w_stall;

    // w_kind: 0 = unknown letter, 1 = no length, 2 = length follows
    always_comb begin
        w_code = 3'd0;
        w_kind = 2'd0;
        case (bus.rx_data)
            "r": begin w_code = 3'd0; w_kind = 2'd1; end
            "s": begin w_code = 3'd1; w_kind = 2'd2; end
            "g": begin w_code = 3'd2; w_kind = 2'd2; end
            "i": begin w_code = 3'd3; w_kind = 2'd2; end
            "o": begin w_code = 3'd4; w_kind = 2'd2; end
            "e": begin w_code = 3'd5; w_kind = 2'd2; end
            "f": begin w_code = 3'd6; w_kind = 2'd1; end
            "p": begin w_code = 3'd7; w_kind = 2'd1; end
            default: begin w_code = 3'd0; w_kind = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_len   <= '0;
            r_bit_valid <= 1'b0;
            r_bit_data  <= 1'b0;
            r_bit_last  <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
            r_acc       <= '0;
            r_byte_cnt  <= '0;
            r_remain    <= '0;
            r_tmo       <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;

            if (r_state == ST_IDLE || bus.rx_valid)
                r_tmo <= '0;
            else if (!w_stall)
                r_tmo <= r_tmo + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        if (w_kind == 2'd1) begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_code  <= w_code;
                            r_cmd_len   <= '0;
                        end else if (w_kind == 2'd2) begin
                            r_cmd_code  <= w_code;
                            r_acc       <= '0;
                            r_byte_cnt  <= '0;
                            r_state     <= ST_LEN;
                        end else begin
                            r_err       <= 1'b1;
                            r_err_code  <= 3'd1;
                        end
                    end
                end

                ST_LEN: begin
                    if (bus.rx_valid) begin
                        r_acc      <= w_acc_next;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        if (w_last_len_byte) begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_len   <= w_acc_next;
                            // Only 's' and 'i' carry a payload.
                            if ((r_cmd_code == 3'd1 || r_cmd_code == 3'd3) && w_acc_next != '0) begin
                                r_remain <= w_acc_next;
                                r_state  <= ST_PAYLOAD;
                            end else begin
                                r_state  <= ST_IDLE;
                            end
                        end
                    end else if (w_tmo_hit) begin
                        r_err      <= 1'b1;
                        r_err_code <= 3'd4;
                        r_state    <= ST_IDLE;
                    end
                end

                ST_PAYLOAD: begin
                    if (bus.rx_valid) begin
                        if (w_stall) begin
                            r_err       <= 1'b1;
                            r_err_code  <= 3'd3;
                            r_bit_valid <= 1'b0;
                            r_bit_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else if (w_accept && r_bit_last) begin
                            // Surplus byte arriving with the final handoff is dropped.
                            r_bit_valid <= 1'b0;
                            r_bit_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else if (w_is_digit) begin
                            r_bit_valid <= 1'b1;
                            r_bit_data  <= bus.rx_data[0];
                            r_bit_last  <= (r_remain == W'(1));
                            r_remain    <= r_remain - W'(1);
                        end else begin
                            r_err       <= 1'b1;
                            r_err_code  <= 3'd2;
                            r_bit_valid <= 1'b0;
                            r_bit_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end else if (w_accept && r_bit_last) begin
                        r_bit_valid <= 1'b0;
                        r_bit_last  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_tmo_hit) begin
                        r_err       <= 1'b1;
                        r_err_code  <= 3'd4;
                        r_bit_valid <= 1'b0;
                        r_bit_last  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_accept) begin
                        r_bit_valid <= 1'b0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_code  = r_cmd_code;
    assign bus.cmd_len   = r_cmd_len;
    assign bus.bit_valid = r_bit_valid;
    assign bus.bit_data  = r_bit_data;
    assign bus.bit_last  = r_bit_last;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.err       = r_err;
    assign bus.err_code  = r_err_code;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_part_cmd_parser.sv
// Directed bench for part_cmd_parser: command decode, length, payload bits,
// errors, timeout and reset, with hand-computed expectations.
module tb_part_cmd_parser;
    localparam int LB = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic flag;

    always #5 clk = ~clk;

    part_cmd_parser_if #(.LEN_BYTES(LB)) bus ();

    part_cmd_parser #(.LEN_BYTES(LB), .TIMEOUT(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.bit_ready = 1'b0;
        rst           = 1'b1;
        idle(3);
        check("rst_state",     32'(bus.dbg_state), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
        rst = 1'b0;
        idle(1);

        // "s" 0x0003 "101" with consumer always ready
        bus.bit_ready = 1'b1;
        send("s");
        check("s_busy",   32'(bus.busy),     32'd1);
        check("s_code",   32'(bus.cmd_code), 32'd1);
        send(8'h00);
        check("s_nocmd",  32'(bus.cmd_valid), 32'd0);
        send(8'h03);
        check("s_cmdv",   32'(bus.cmd_valid), 32'd1);
        check("s_len",    32'(bus.cmd_len),   32'd3);
        check("s_state",  32'(bus.dbg_state), 32'd2);
        send("1");
        check("s_b0",     {29'd0, bus.bit_valid, bus.bit_data, bus.bit_last}, 32'b110);
        send("0");
        check("s_b1",     {29'd0, bus.bit_valid, bus.bit_data, bus.bit_last}, 32'b100);
        check("s_b1_err", 32'(bus.err), 32'd0);
        send("1");
        check("s_b2",     {29'd0, bus.bit_valid, bus.bit_data, bus.bit_last}, 32'b111);
        idle(1);
        check("s_done_bv",   32'(bus.bit_valid), 32'd0);
        check("s_done_busy", 32'(bus.busy),      32'd0);

        // "g" 0x0006: length only, no payload
        send("g");
        send(8'h00);
        send(8'h06);
        check("g_cmdv",  32'(bus.cmd_valid), 32'd1);
        check("g_code",  32'(bus.cmd_code),  32'd2);
        check("g_len",   32'(bus.cmd_len),   32'd6);
        check("g_state", 32'(bus.dbg_state), 32'd0);
        idle(1);
        check("g_single", 32'(bus.cmd_valid), 32'd0);
        check("g_nobit",  32'(bus.bit_valid), 32'd0);

        // Unknown letter, then "p"
        send("x");
        check("x_err",  32'(bus.err),      32'd1);
        check("x_code", 32'(bus.err_code), 32'd1);
        check("x_nocmd", 32'(bus.cmd_valid), 32'd0);
        idle(1);
        check("x_err_pulse", 32'(bus.err),      32'd0);
        check("x_code_hold", 32'(bus.err_code), 32'd1);
        send("p");
        check("p_cmdv", 32'(bus.cmd_valid), 32'd1);
        check("p_code", 32'(bus.cmd_code),  32'd7);
        check("p_len",  32'(bus.cmd_len),   32'd0);

        // Overflow: second digit while first bit is unaccepted
        bus.bit_ready = 1'b0;
        send("i");
        send(8'h00);
        send(8'h02);
        check("i_len",   32'(bus.cmd_len),   32'd2);
        check("i_state", 32'(bus.dbg_state), 32'd2);
        send("1");
        idle(3);
        check("i_hold", {29'd0, bus.bit_valid, bus.bit_data, bus.bit_last}, 32'b110);
        send("0");
        check("ovf_err",   32'(bus.err),       32'd1);
        check("ovf_code",  32'(bus.err_code),  32'd3);
        check("ovf_bv",    32'(bus.bit_valid), 32'd0);
        check("ovf_state", 32'(bus.dbg_state), 32'd0);

        // Timeout 50 cycles after the last length byte
        send("e");
        send(8'h00);
        flag = 1'b0;
        for (int i = 0; i < 49; i++) begin
            idle(1);
            if (bus.err) flag = 1'b1;
        end
        check("tmo_early", 32'(flag), 32'd0);
        idle(1);
        check("tmo_err",   32'(bus.err),       32'd1);
        check("tmo_code",  32'(bus.err_code),  32'd4);
        check("tmo_state", 32'(bus.dbg_state), 32'd0);

        // Largest length, no payload for "o"
        send("o");
        send(8'hFF);
        send(8'hFF);
        check("max_len",   32'(bus.cmd_len),   32'd65535);
        check("max_state", 32'(bus.dbg_state), 32'd0);

        // Zero-length "s" returns to IDLE
        send("s");
        send(8'h00);
        send(8'h00);
        check("zero_cmdv",  32'(bus.cmd_valid), 32'd1);
        check("zero_state", 32'(bus.dbg_state), 32'd0);

        // Bad payload digit
        bus.bit_ready = 1'b1;
        send("s");
        send(8'h00);
        send(8'h02);
        send("7");
        check("bad_err",   32'(bus.err),       32'd1);
        check("bad_code",  32'(bus.err_code),  32'd2);
        check("bad_state", 32'(bus.dbg_state), 32'd0);

        // Timeout frozen while a bit waits for the consumer
        bus.bit_ready = 1'b0;
        send("i");
        send(8'h00);
        send(8'h02);
        send("1");
        flag = 1'b0;
        for (int i = 0; i < 60; i++) begin
            idle(1);
            if (bus.err || !bus.bit_valid) flag = 1'b1;
        end
        check("frz_hold", 32'(flag), 32'd0);
        bus.bit_ready = 1'b1;
        idle(1);
        check("frz_acc", {30'd0, bus.bit_valid, bus.busy}, 32'b01);
        send("0");
        check("frz_last", {29'd0, bus.bit_valid, bus.bit_data, bus.bit_last}, 32'b101);
        idle(1);
        check("frz_done", 32'(bus.dbg_state), 32'd0);

        // Reset mid-payload, after 1 of 4 bits
        send("s");
        send(8'h00);
        send(8'h04);
        send("1");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_outs", {bus.cmd_valid, bus.cmd_code, 16'(bus.cmd_len), bus.bit_valid,
                               bus.bit_data, bus.bit_last, bus.busy, bus.err, bus.err_code},
              32'd0);
        check("mid_rst_state", 32'(bus.dbg_state), 32'd0);
        idle(2);
        check("mid_rst_quiet", {30'd0, bus.cmd_valid, bus.err}, 32'd0);
        send("r");
        check("r_cmdv", 32'(bus.cmd_valid), 32'd1);
        check("r_code", 32'(bus.cmd_code),  32'd0);
        check("r_len",  32'(bus.cmd_len),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/part_cmd_parser.md
PART_CMD_PARSER -- requirements
Module: part_cmd_parser

Interface
REQ-001 SHALL have parameter LEN_BYTES, default 2, number of big-endian length bytes following a length-carrying command (1..4).
REQ-002 SHALL have parameter TIMEOUT, default 100000, clk cycles allowed between bytes inside a command (0 = timeout disabled).
REQ-003 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-006 SHALL have port rx_data  in  8  received UART byte.
REQ-007 SHALL have port cmd_valid  out  1  one-cycle command strobe.
REQ-008 SHALL have port cmd_code  out  3  r=0 s=1 g=2 i=3 o=4 e=5 f=6 p=7.
REQ-009 SHALL have port cmd_len  out  8*LEN_BYTES  decoded length, 0 for r/f/p.
REQ-010 SHALL have port bit_valid  out  1  payload bit available.
REQ-011 SHALL have port bit_data  out  1  payload bit value.
REQ-012 SHALL have port bit_last  out  1  marks the final payload bit.
REQ-013 SHALL have port bit_ready  in  1  consumer accepts bit when bit_valid&bit_ready.
REQ-014 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-015 SHALL have port err  out  1  one-cycle error strobe.
REQ-016 SHALL have port err_code  out  3  1 unknown cmd, 2 bad digit, 3 overflow, 4 timeout; held until the next err.

Function
REQ-017 SHALL implement states IDLE, LEN, PAYLOAD.
REQ-018 IDLE + rx_valid with "r", "f" or "p" SHALL pulse cmd_valid the next cycle with cmd_len=0 and remain in IDLE.
REQ-019 IDLE + rx_valid with "s", "g", "i", "o" or "e" SHALL latch cmd_code, clear the length accumulator and byte counter, and enter LEN.
REQ-020 IDLE + any other byte SHALL pulse err with err_code=1 and remain in IDLE.
REQ-021 In LEN, each rx_valid SHALL shift the byte into the length accumulator MSB-first; any byte value is legal.
REQ-022 After the LEN_BYTES-th byte, the block SHALL pulse cmd_valid with the full cmd_len the next cycle.
REQ-023 After the cmd_valid of REQ-022, it SHALL enter PAYLOAD if cmd_code is s or i and length>0; otherwise it SHALL return to IDLE.
REQ-024 In PAYLOAD, byte "0"/"1" SHALL load bit_data=0/1 and assert bit_valid the next cycle; bit_valid, bit_data and bit_last SHALL hold stable until accepted.
REQ-025 bit_last SHALL be high on the bit whose index equals cmd_len-1; a remaining-bit counter of width 8*LEN_BYTES SHALL decrement on each loaded byte.
REQ-026 Acceptance of the bit_last bit SHALL return the state to IDLE the same edge.
REQ-027 In PAYLOAD, a byte other than "0"/"1" SHALL pulse err with err_code=2, deassert bit_valid, and return to IDLE.
REQ-028 A rx_valid while bit_valid=1 and bit_ready=0 SHALL pulse err with err_code=3, drop the byte, deassert bit_valid, and return to IDLE.
REQ-029 A rx_valid in the same cycle as bit_valid&bit_ready SHALL be a legal handoff: the old bit is accepted, the new bit is loaded, and no error is raised.
REQ-030 In LEN/PAYLOAD with TIMEOUT>0, a counter SHALL clear on every rx_valid; reaching TIMEOUT SHALL pulse err with err_code=4, deassert bit_valid, and return to IDLE; the counter SHALL be frozen while bit_valid waits for bit_ready.
REQ-031 Maximum length 2^(8*LEN_BYTES)-1 SHALL be supported without wrap.
REQ-032 cmd_valid and err SHALL never assert in the same cycle.

Reset
REQ-033 rst=1 at any state, including mid-command, SHALL force the next-cycle values IDLE, cmd_valid=0, cmd_code=0, cmd_len=0, bit_valid=0, bit_data=0, bit_last=0, busy=0, err=0, err_code=0, and all counters to 0.
REQ-034 A partially received command SHALL be discarded by reset; no cmd_valid or err pulse SHALL result from it.

Verification
REQ-035 Bytes "s",0x00,0x03,"1","0","1" with bit_ready=1 -> cmd_valid with code 1 and len 3, then bits 1,0,1 with bit_last on the third, then busy=0.
REQ-036 Bytes "g",0x00,0x06 -> one cmd_valid with code 2 and len 6, no bit_valid, state IDLE.
REQ-037 Byte "x" in IDLE -> err with code 1; a following "p" -> cmd_valid with code 7 and len 0.
REQ-038 Bytes "i",0x00,0x02,"1", bit_ready=0, then "0" -> err with code 3, bit_valid=0, state IDLE.
REQ-039 With TIMEOUT=50, bytes "e",0x00 then silence -> err with code 4 exactly 50 cycles after 0x00, state IDLE.
REQ-040 rst pulse during PAYLOAD after 1 of 4 bits -> all outputs 0 and IDLE the next cycle; a subsequent "r" -> cmd_valid with code 0.
